// File: rtl/hilo_div_ctrl.sv
// HI/LO divide sequencer: restoring divider, one quotient bit per cycle.
// Ports: start_i/signed_i/opdata*_i request, annul_i cancel,
//        busy_o stall, hilo_we_o + hi_o/lo_o/div0_o write-back.
module hilo_div_ctrl #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic              signed_i,
  input  logic [DATA_W-1:0] opdata1_i,
  input  logic [DATA_W-1:0] opdata2_i,
  input  logic              annul_i,
  output logic              busy_o,
  output logic              hilo_we_o,
  output logic [DATA_W-1:0] hi_o,
  output logic [DATA_W-1:0] lo_o,
  output logic              div0_o
);

  localparam int CW = $clog2(DATA_W) + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_DIVZERO,
    S_ON,
    S_END
  } state_e;

  state_e state_q, state_d;

  logic [CW-1:0]     cnt_q, cnt_d;
  logic [DATA_W-1:0] rem_q, rem_d;
  logic [DATA_W-1:0] quot_q, quot_d;
  logic [DATA_W-1:0] dvsr_q, dvsr_d;
  logic              rneg_q, rneg_d;
  logic              qneg_q, qneg_d;
  logic              sgn_q, sgn_d;
  logic [DATA_W-1:0] hi_q, hi_d;
  logic [DATA_W-1:0] lo_q, lo_d;
  logic              div0_q, div0_d;

  logic [DATA_W:0]   rem_sh;
  logic              ge;
  logic [DATA_W-1:0] rem_n;
  logic [DATA_W-1:0] quot_n;
  logic [DATA_W-1:0] q_fix;
  logic [DATA_W-1:0] r_fix;
  logic [DATA_W-1:0] a_abs;
  logic [DATA_W-1:0] b_abs;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      quot_q  <= '0;
      dvsr_q  <= '0;
      rneg_q  <= 1'b0;
      qneg_q  <= 1'b0;
      sgn_q   <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      div0_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      quot_q  <= quot_d;
      dvsr_q  <= dvsr_d;
      rneg_q  <= rneg_d;
      qneg_q  <= qneg_d;
      sgn_q   <= sgn_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      div0_q  <= div0_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    quot_d  = quot_q;
    dvsr_d  = dvsr_q;
    rneg_d  = rneg_q;
    qneg_d  = qneg_q;
    sgn_d   = sgn_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    div0_d  = div0_q;

    // {rem,quot} shifted left; rem stays below divisor,
    // so the low DATA_W bits of the difference are exact.
    rem_sh = {rem_q, quot_q[DATA_W-1]};
    ge     = rem_sh >= {1'b0, dvsr_q};
    rem_n  = ge ? (rem_sh[DATA_W-1:0] - dvsr_q)
                : rem_sh[DATA_W-1:0];
    quot_n = {quot_q[DATA_W-2:0], ge};

    q_fix = (sgn_q & qneg_q) ? -quot_n : quot_n;
    r_fix = (sgn_q & rneg_q) ? -rem_n : rem_n;

    // Negating the most-negative value yields its unsigned magnitude.
    a_abs = (signed_i & opdata1_i[DATA_W-1]) ? -opdata1_i : opdata1_i;
    b_abs = (signed_i & opdata2_i[DATA_W-1]) ? -opdata2_i : opdata2_i;

    unique case (state_q)
      S_IDLE: begin
        if (start_i && !annul_i) begin
          state_d = (opdata2_i == '0) ? S_DIVZERO : S_ON;
          cnt_d   = '0;
          rem_d   = '0;
          quot_d  = a_abs;
          dvsr_d  = b_abs;
          rneg_d  = opdata1_i[DATA_W-1];
          qneg_d  = opdata1_i[DATA_W-1] ^ opdata2_i[DATA_W-1];
          sgn_d   = signed_i;
        end
      end
      S_DIVZERO: begin
        if (annul_i) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_END;
          hi_d    = '0;
          lo_d    = '0;
          div0_d  = 1'b1;
        end
      end
      S_ON: begin
        if (annul_i) begin
          state_d = S_IDLE;
        end else begin
          rem_d  = rem_n;
          quot_d = quot_n;
          cnt_d  = cnt_q + CW'(1);
          if (cnt_q == CW'(DATA_W - 1)) begin
            state_d = S_END;
            hi_d    = r_fix;
            lo_d    = q_fix;
            div0_d  = 1'b0;
          end
        end
      end
      S_END: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign busy_o    = (state_q == S_ON) || (state_q == S_DIVZERO);
  assign hilo_we_o = (state_q == S_END) && !annul_i;
  assign hi_o      = hi_q;
  assign lo_o      = lo_q;
  assign div0_o    = div0_q;

endmodule

// File: tb/tb_hilo_div_ctrl.sv
// Bench for hilo_div_ctrl: vector table of divides plus
// hand-written annul, ignore-start and mid-run reset sequences.
module tb_hilo_div_ctrl;

  logic        clk;
  logic        rst;
  logic        start_i;
  logic        signed_i;
  logic [31:0] opdata1_i;
  logic [31:0] opdata2_i;
  logic        annul_i;
  logic        busy_o;
  logic        hilo_we_o;
  logic [31:0] hi_o;
  logic [31:0] lo_o;
  logic        div0_o;

  int n_chk;
  int n_fail;

  hilo_div_ctrl #(.DATA_W(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .start_i   (start_i),
    .signed_i  (signed_i),
    .opdata1_i (opdata1_i),
    .opdata2_i (opdata2_i),
    .annul_i   (annul_i),
    .busy_o    (busy_o),
    .hilo_we_o (hilo_we_o),
    .hi_o      (hi_o),
    .lo_o      (lo_o),
    .div0_o    (div0_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       nm;
    logic        sg;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] ehi;
    logic [31:0] elo;
    logic        ez;
    int          elat;
  } vec_t;

  vec_t tbl[10];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Cycle 0 = start driven; returns when the write is seen or bound hit.
  task automatic run_op(input vec_t v);
    int   cyc;
    logic done;
    logic bok;
    @(negedge clk);
    start_i   = 1'b1;
    signed_i  = v.sg;
    opdata1_i = v.a;
    opdata2_i = v.b;
    annul_i   = 1'b0;
    #1;
    chk({v.nm, " idle_busy"}, {31'd0, busy_o}, 32'd0);
    cyc  = 0;
    done = 1'b0;
    bok  = 1'b1;
    while (!done && cyc < 40) begin
      @(negedge clk);
      start_i = 1'b0;
      cyc++;
      #1;
      if (hilo_we_o) done = 1'b1;
      else if (!busy_o) bok = 1'b0;
    end
    chk({v.nm, " latency"}, cyc, v.elat);
    chk({v.nm, " busy_run"}, {31'd0, bok}, 32'd1);
    chk({v.nm, " busy_wr"}, {31'd0, busy_o}, 32'd0);
    chk({v.nm, " hi"}, hi_o, v.ehi);
    chk({v.nm, " lo"}, lo_o, v.elo);
    chk({v.nm, " div0"}, {31'd0, div0_o}, {31'd0, v.ez});
    @(negedge clk);
    #1;
    chk({v.nm, " after_we"}, {31'd0, hilo_we_o}, 32'd0);
  endtask

  initial begin
    int   cyc;
    logic done;
    logic [31:0] phi;
    logic [31:0] plo;
    vec_t v;

    n_chk  = 0;
    n_fail = 0;

    tbl[0] = '{"divu_100_7", 1'b0, 32'd100, 32'd7,
               32'd2, 32'd14, 1'b0, 33};
    tbl[1] = '{"div_m7_2", 1'b1, 32'hFFFFFFF9, 32'd2,
               32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 33};
    tbl[2] = '{"div_7_m2", 1'b1, 32'd7, 32'hFFFFFFFE,
               32'd1, 32'hFFFFFFFD, 1'b0, 33};
    tbl[3] = '{"divu_5_0", 1'b0, 32'd5, 32'd0,
               32'd0, 32'd0, 1'b1, 2};
    tbl[4] = '{"div_min_m1", 1'b1, 32'h80000000, 32'hFFFFFFFF,
               32'd0, 32'h80000000, 1'b0, 33};
    tbl[5] = '{"divu_min_max", 1'b0, 32'h80000000, 32'hFFFFFFFF,
               32'h80000000, 32'd0, 1'b0, 33};
    tbl[6] = '{"divu_max_1", 1'b0, 32'hFFFFFFFF, 32'd1,
               32'd0, 32'hFFFFFFFF, 1'b0, 33};
    tbl[7] = '{"divu_3_10", 1'b0, 32'd3, 32'd10,
               32'd3, 32'd0, 1'b0, 33};
    tbl[8] = '{"div_0_0", 1'b1, 32'd0, 32'd0,
               32'd0, 32'd0, 1'b1, 2};
    tbl[9] = '{"div_m100_m7", 1'b1, 32'hFFFFFF9C, 32'hFFFFFFF9,
               32'hFFFFFFFE, 32'd14, 1'b0, 33};

    rst       = 1'b1;
    start_i   = 1'b0;
    signed_i  = 1'b0;
    opdata1_i = '0;
    opdata2_i = '0;
    annul_i   = 1'b0;
    #12;
    chk("rst busy", {31'd0, busy_o}, 32'd0);
    chk("rst we", {31'd0, hilo_we_o}, 32'd0);
    chk("rst hi", hi_o, 32'd0);
    chk("rst lo", lo_o, 32'd0);
    chk("rst div0", {31'd0, div0_o}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 10; i++) run_op(tbl[i]);

    // Annul mid-run; a second start during ON must be ignored.
    phi = tbl[9].ehi;
    plo = tbl[9].elo;
    @(negedge clk);
    start_i   = 1'b1;
    signed_i  = 1'b0;
    opdata1_i = 32'd1000;
    opdata2_i = 32'd3;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      start_i = (c == 5);
      if (c == 5) begin
        opdata1_i = 32'd9;
        opdata2_i = 32'd0;
      end
      annul_i = (c == 10);
      #1;
      chk($sformatf("ann busy c%0d", c), {31'd0, busy_o}, 32'd1);
    end
    @(negedge clk);
    annul_i   = 1'b0;
    start_i   = 1'b1;
    opdata1_i = 32'd100;
    opdata2_i = 32'd7;
    #1;
    chk("ann c11 busy", {31'd0, busy_o}, 32'd0);
    chk("ann c11 we", {31'd0, hilo_we_o}, 32'd0);
    chk("ann hold hi", hi_o, phi);
    chk("ann hold lo", lo_o, plo);
    cyc  = 11;
    done = 1'b0;
    while (!done && cyc < 60) begin
      @(negedge clk);
      start_i = 1'b0;
      cyc++;
      #1;
      if (hilo_we_o) done = 1'b1;
    end
    chk("ann restart cycle", cyc, 44);
    chk("ann restart hi", hi_o, 32'd2);
    chk("ann restart lo", lo_o, 32'd14);

    // Annul during END suppresses the write but results still load.
    @(negedge clk);
    @(negedge clk);
    start_i   = 1'b1;
    signed_i  = 1'b0;
    opdata1_i = 32'd50;
    opdata2_i = 32'd5;
    for (int c = 1; c <= 32; c++) begin
      @(negedge clk);
      start_i = 1'b0;
    end
    @(negedge clk);
    annul_i = 1'b1;
    #1;
    chk("end annul we", {31'd0, hilo_we_o}, 32'd0);
    chk("end annul busy", {31'd0, busy_o}, 32'd0);
    chk("end annul lo", lo_o, 32'd10);
    chk("end annul hi", hi_o, 32'd0);
    @(negedge clk);
    annul_i = 1'b0;
    #1;
    chk("end annul next we", {31'd0, hilo_we_o}, 32'd0);

    // start with annul in the same cycle is dropped.
    @(negedge clk);
    start_i   = 1'b1;
    annul_i   = 1'b1;
    opdata1_i = 32'd100;
    opdata2_i = 32'd7;
    @(negedge clk);
    start_i = 1'b0;
    annul_i = 1'b0;
    #1;
    chk("st+ann busy", {31'd0, busy_o}, 32'd0);
    @(negedge clk);
    #1;
    chk("st+ann we", {31'd0, hilo_we_o}, 32'd0);

    // Annul in DIVZERO: no write, flag and results untouched.
    @(negedge clk);
    start_i   = 1'b1;
    opdata1_i = 32'd5;
    opdata2_i = 32'd0;
    @(negedge clk);
    start_i = 1'b0;
    annul_i = 1'b1;
    #1;
    chk("dz annul busy", {31'd0, busy_o}, 32'd1);
    @(negedge clk);
    annul_i = 1'b0;
    #1;
    chk("dz annul we", {31'd0, hilo_we_o}, 32'd0);
    chk("dz annul busy2", {31'd0, busy_o}, 32'd0);
    chk("dz annul div0", {31'd0, div0_o}, 32'd0);
    chk("dz annul lo", lo_o, 32'd10);

    // Reset between edges mid-run.
    run_op(tbl[0]);
    @(negedge clk);
    start_i   = 1'b1;
    signed_i  = 1'b0;
    opdata1_i = 32'd100;
    opdata2_i = 32'd7;
    for (int c = 1; c <= 15; c++) begin
      @(negedge clk);
      start_i = 1'b0;
    end
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("mid rst busy", {31'd0, busy_o}, 32'd0);
    chk("mid rst hi", hi_o, 32'd0);
    chk("mid rst lo", lo_o, 32'd0);
    chk("mid rst we", {31'd0, hilo_we_o}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    done = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      #1;
      if (hilo_we_o || busy_o) done = 1'b1;
    end
    chk("post rst quiet", {31'd0, done}, 32'd0);
    v = tbl[0];
    v.nm = "post_rst_divu";
    run_op(v);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
